// File: rtl/simd_mac_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : simd_mac_if                                             |
// | Brief  : Beat/result handshake bundle for simd_mac_pipe.         |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
interface simd_mac_if #(
  parameter int DATA_WIDTH = 64
) ();
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   input_data;
  logic [DATA_WIDTH-1:0]   weight;
  logic [1:0]              prec_mode;
  logic                    is_signed;
  logic                    in_first;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [2*DATA_WIDTH-1:0] res_mac;
  logic                    ovf;
  logic                    err;

  // Feeder / result-consumer side
  modport master (
    output in_valid, input_data, weight, prec_mode, is_signed, in_first, in_last, out_ready,
    input  in_ready, out_valid, res_mac, ovf, err
  );

  // MAC unit side
  modport slave (
    input  in_valid, input_data, weight, prec_mode, is_signed, in_first, in_last, out_ready,
    output in_ready, out_valid, res_mac, ovf, err
  );
endinterface
`default_nettype wire

// File: rtl/simd_mac_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : simd_mac_pipe                                           |
// | Brief  : 3-stage SIMD multiply-accumulate, int8/16/32 lanes,     |
// |          burst accumulation, saturating or wrapping.             |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module simd_mac_pipe #(
  parameter int    DATA_WIDTH = 64,
  parameter int    SATURATE   = 1,
  parameter string USE_FABRIC = "NO"
) (
  input logic       clk,
  input logic       resetn,
  simd_mac_if.slave bus
);
  localparam int P2 = 2 * DATA_WIDTH;

  logic stall;
  assign stall = bus.out_valid & ~bus.out_ready;

  // Stage 1 state
  logic                  s1_valid, s1_signed, s1_first, s1_last;
  logic [1:0]            s1_mode;
  logic [DATA_WIDTH-1:0] s1_a, s1_b;
  // Stage 2 state
  logic                  s2_valid, s2_signed, s2_first, s2_last;
  logic [1:0]            s2_mode;
  logic [P2-1:0]         s2_prod;
  // Accumulator and result state
  logic [P2-1:0]         acc, res_q;
  logic [1:0]            acc_mode;
  logic                  acc_signed, acc_ovf, err_q, out_valid_q;

  logic [P2-1:0] prod_m [3];
  logic [P2-1:0] sum_m  [3];
  logic [2:0]    ovf_m;
  logic [P2-1:0] prod_sel, acc_next;
  logic          ovf_sel, legal, mismatch, eff_first;

  assign legal     = (s2_mode != 2'b11);
  assign mismatch  = ~s2_first & ((s2_mode != acc_mode) | (s2_signed != acc_signed));
  assign eff_first = s2_first | mismatch;

  // One multiplier/adder bank per lane width; the active mode picks its bank.
  for (genvar m = 0; m < 3; m++) begin : g_mode
    localparam int W = 8 << m;
    localparam int N = DATA_WIDTH / W;
    logic [P2-1:0] prod_v, sum_v;
    logic [N-1:0]  lane_ovf;

    for (genvar i = 0; i < N; i++) begin : g_lane
      logic [W-1:0]   a, b;
      logic [2*W-1:0] ax, bx, prod, acc_l, p_l, base, sat;
      logic [2*W:0]   sum;
      logic           of;

      // Sign-extending to 2W makes one unsigned multiply exact for both signednesses.
      assign a  = s1_a[W*i +: W];
      assign b  = s1_b[W*i +: W];
      assign ax = {{W{s1_signed & a[W-1]}}, a};
      assign bx = {{W{s1_signed & b[W-1]}}, b};

      if (USE_FABRIC == "YES") begin : g_fabric
        (* use_dsp = "no" *) logic [2*W-1:0] p;
        assign p    = ax * bx;
        assign prod = p;
      end else begin : g_dsp
        (* use_dsp = "yes" *) logic [2*W-1:0] p;
        assign p    = ax * bx;
        assign prod = p;
      end
      assign prod_v[2*W*i +: 2*W] = prod;

      // One extra sum bit exposes overflow in either signedness.
      assign acc_l = acc[2*W*i +: 2*W];
      assign p_l   = s2_prod[2*W*i +: 2*W];
      assign base  = eff_first ? '0 : acc_l;
      assign sum   = s2_signed ? ({base[2*W-1], base} + {p_l[2*W-1], p_l})
                               : ({1'b0, base} + {1'b0, p_l});
      assign of    = s2_signed ? (sum[2*W] ^ sum[2*W-1]) : sum[2*W];
      assign sat   = !s2_signed ? {(2*W){1'b1}}
                   : (sum[2*W] ? {1'b1, {(2*W-1){1'b0}}} : {1'b0, {(2*W-1){1'b1}}});
      assign sum_v[2*W*i +: 2*W] = (of && (SATURATE != 0)) ? sat : sum[2*W-1:0];
      assign lane_ovf[i] = of;
    end

    assign prod_m[m] = prod_v;
    assign sum_m[m]  = sum_v;
    assign ovf_m[m]  = |lane_ovf;
  end

  // Select the product bank of the beat sitting in stage 1.
  always_comb begin
    prod_sel = prod_m[2];
    case (s1_mode)
      2'b00:   prod_sel = prod_m[0];
      2'b01:   prod_sel = prod_m[1];
      default: prod_sel = prod_m[2];
    endcase
  end

  // Select the accumulate result of the beat sitting in stage 2.
  always_comb begin
    acc_next = sum_m[2];
    ovf_sel  = ovf_m[2];
    case (s2_mode)
      2'b00:   begin acc_next = sum_m[0]; ovf_sel = ovf_m[0]; end
      2'b01:   begin acc_next = sum_m[1]; ovf_sel = ovf_m[1]; end
      default: begin acc_next = sum_m[2]; ovf_sel = ovf_m[2]; end
    endcase
  end

  // Stage 1: capture operands and control of an accepted beat.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_valid <= 1'b0; s1_signed <= 1'b0; s1_first <= 1'b0; s1_last <= 1'b0;
      s1_mode  <= 2'b00; s1_a <= '0; s1_b <= '0;
    end else if (!stall) begin
      s1_valid  <= bus.in_valid;
      s1_signed <= bus.is_signed;
      s1_first  <= bus.in_first;
      s1_last   <= bus.in_last;
      s1_mode   <= bus.prec_mode;
      s1_a      <= bus.input_data;
      s1_b      <= bus.weight;
    end
  end

  // Stage 2: register lane products.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s2_valid <= 1'b0; s2_signed <= 1'b0; s2_first <= 1'b0; s2_last <= 1'b0;
      s2_mode  <= 2'b00; s2_prod <= '0;
    end else if (!stall) begin
      s2_valid  <= s1_valid;
      s2_signed <= s1_signed;
      s2_first  <= s1_first;
      s2_last   <= s1_last;
      s2_mode   <= s1_mode;
      s2_prod   <= prod_sel;
    end
  end

  // Stage 3: accumulate, track flags, and load the result register on a last beat.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      acc <= '0; acc_mode <= 2'b00; acc_signed <= 1'b0; acc_ovf <= 1'b0;
      err_q <= 1'b0; res_q <= '0; out_valid_q <= 1'b0;
    end else if (!stall) begin
      out_valid_q <= s2_valid & s2_last & legal;
      if (s2_valid) begin
        if (!legal) begin
          err_q <= 1'b1;
        end else begin
          acc        <= acc_next;
          acc_mode   <= s2_mode;
          acc_signed <= s2_signed;
          acc_ovf    <= ovf_sel | (acc_ovf & ~eff_first);
          if (mismatch) err_q <= 1'b1;
          if (s2_last)  res_q <= acc_next;
        end
      end
    end
  end

  assign bus.in_ready  = ~stall;
  assign bus.out_valid = out_valid_q;
  assign bus.res_mac   = res_q;
  assign bus.ovf       = acc_ovf;
  assign bus.err       = err_q;
endmodule
`default_nettype wire

// File: tb/tb_simd_mac_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_simd_mac_pipe                                        |
// | Brief  : Scoreboard bench; saturating and wrapping instances     |
// |          share one stimulus stream.                              |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module tb_simd_mac_pipe;
  localparam int DW = 64;

  typedef struct {
    logic [2*DW-1:0] res;
    logic            ovf;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  int   checks = 0;
  int   errors = 0;
  logic [2*DW-1:0] held_a, held_b;
  bit   stalled_a = 0, stalled_b = 0;

  always #5 clk = ~clk;

  simd_mac_if #(.DATA_WIDTH(DW)) bus_a ();
  simd_mac_if #(.DATA_WIDTH(DW)) bus_b ();

  assign bus_b.in_valid   = bus_a.in_valid;
  assign bus_b.input_data = bus_a.input_data;
  assign bus_b.weight     = bus_a.weight;
  assign bus_b.prec_mode  = bus_a.prec_mode;
  assign bus_b.is_signed  = bus_a.is_signed;
  assign bus_b.in_first   = bus_a.in_first;
  assign bus_b.in_last    = bus_a.in_last;
  assign bus_b.out_ready  = bus_a.out_ready;

  simd_mac_pipe #(.DATA_WIDTH(DW), .SATURATE(1), .USE_FABRIC("NO"))
    dut_sat (.clk(clk), .resetn(resetn), .bus(bus_a));
  simd_mac_pipe #(.DATA_WIDTH(DW), .SATURATE(0), .USE_FABRIC("YES"))
    dut_wrap (.clk(clk), .resetn(resetn), .bus(bus_b));

  task automatic check(input string name, input logic [2*DW-1:0] act, input logic [2*DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor for the saturating instance: pop and compare on each handshake.
  always @(negedge clk) begin
    if (resetn && bus_a.out_valid) begin
      if (!bus_a.out_ready) begin
        check("stall_in_ready_sat", {127'd0, bus_a.in_ready}, '0);
        if (stalled_a) check("stall_hold_sat", bus_a.res_mac, held_a);
        held_a    = bus_a.res_mac;
        stalled_a = 1;
      end else begin
        stalled_a = 0;
        if (q_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out_sat actual=%h required=none", bus_a.res_mac);
        end else begin
          e_a = q_a.pop_front();
          check("res_sat", bus_a.res_mac, e_a.res);
          check("ovf_sat", {127'd0, bus_a.ovf}, {127'd0, e_a.ovf});
        end
      end
    end else begin
      stalled_a = 0;
    end
  end

  // Monitor for the wrapping instance.
  always @(negedge clk) begin
    if (resetn && bus_b.out_valid) begin
      if (!bus_b.out_ready) begin
        check("stall_in_ready_wrap", {127'd0, bus_b.in_ready}, '0);
        if (stalled_b) check("stall_hold_wrap", bus_b.res_mac, held_b);
        held_b    = bus_b.res_mac;
        stalled_b = 1;
      end else begin
        stalled_b = 0;
        if (q_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out_wrap actual=%h required=none", bus_b.res_mac);
        end else begin
          e_b = q_b.pop_front();
          check("res_wrap", bus_b.res_mac, e_b.res);
          check("ovf_wrap", {127'd0, bus_b.ovf}, {127'd0, e_b.ovf});
        end
      end
    end else begin
      stalled_b = 0;
    end
  end

  task automatic expect_res(input logic [2*DW-1:0] ra, input logic oa,
                            input logic [2*DW-1:0] rb, input logic ob);
    q_a.push_back('{res: ra, ovf: oa});
    q_b.push_back('{res: rb, ovf: ob});
  endtask

  task automatic send(input logic [1:0] mode, input logic sgn, input logic first,
                      input logic last, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int guard = 0;
    @(negedge clk);
    bus_a.in_valid   = 1'b1;
    bus_a.prec_mode  = mode;
    bus_a.is_signed  = sgn;
    bus_a.in_first   = first;
    bus_a.in_last    = last;
    bus_a.input_data = a;
    bus_a.weight     = b;
    while (!bus_a.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!bus_a.in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout actual=0 required=1");
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus_a.in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d/%0d pending required=0", q_a.size(), q_b.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_out_valid"}, {127'd0, bus_a.out_valid | bus_b.out_valid}, '0);
    check({tag, "_res_sat"},   bus_a.res_mac, '0);
    check({tag, "_res_wrap"},  bus_b.res_mac, '0);
    check({tag, "_ovf"},       {127'd0, bus_a.ovf | bus_b.ovf}, '0);
    check({tag, "_err"},       {127'd0, bus_a.err | bus_b.err}, '0);
    check({tag, "_in_ready"},  {127'd0, bus_a.in_ready & bus_b.in_ready}, 128'd1);
  endtask

  initial begin
    bus_a.in_valid   = 1'b0;
    bus_a.input_data = '0;
    bus_a.weight     = '0;
    bus_a.prec_mode  = 2'b00;
    bus_a.is_signed  = 1'b0;
    bus_a.in_first   = 1'b0;
    bus_a.in_last    = 1'b0;
    bus_a.out_ready  = 1'b1;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check_cleared("reset");

    // int8 signed single shot: 127 * 2 = 254
    expect_res(128'h00FE, 1'b0, 128'h00FE, 1'b0);
    send(2'b00, 1'b1, 1'b1, 1'b1, 64'h7F, 64'h02);
    idle();
    drain();

    // int16 unsigned 4-beat burst: 4 * 1000 * 1000 = 4_000_000 per lane
    expect_res({4{32'h003D_0900}}, 1'b0, {4{32'h003D_0900}}, 1'b0);
    for (int k = 0; k < 4; k++)
      send(2'b01, 1'b0, k == 0, k == 3, 64'h03E8_03E8_03E8_03E8, 64'h03E8_03E8_03E8_03E8);
    idle();
    drain();

    // int8 signed: 3 * 16384 clamps to 0x7FFF, wraps to 0xC000; then ovf clears
    expect_res(128'h7FFF, 1'b1, 128'hC000, 1'b1);
    for (int k = 0; k < 3; k++)
      send(2'b00, 1'b1, k == 0, k == 2, 64'h80, 64'h80);
    expect_res(128'h000C, 1'b0, 128'h000C, 1'b0);
    send(2'b00, 1'b1, 1'b1, 1'b1, 64'h03, 64'h04);
    idle();
    drain();

    // Backpressure: results held while out_ready is low, no beat lost
    @(posedge clk);
    #1 bus_a.out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          expect_res({64'd6, 64'((k + 1) << 16)}, 1'b0, {64'd6, 64'((k + 1) << 16)}, 1'b0);
          send(2'b10, 1'b0, 1'b1, 1'b1, {32'd2, 32'(k + 1)}, {32'd3, 32'h0001_0000});
        end
        // int16 signed: 2 * (-1 * 5) = -10 per lane
        expect_res({4{32'hFFFF_FFF6}}, 1'b0, {4{32'hFFFF_FFF6}}, 1'b0);
        send(2'b01, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0005_0005_0005_0005);
        send(2'b01, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0005_0005_0005_0005);
        idle();
      end
      begin
        repeat (12) @(posedge clk);
        #1 bus_a.out_ready = 1'b1;
      end
    join
    drain();

    // Illegal mode: dropped, err set
    check("err_before_illegal", {127'd0, bus_a.err | bus_b.err}, '0);
    send(2'b11, 1'b0, 1'b1, 1'b1, 64'h1234, 64'h5678);
    idle();
    repeat (6) @(negedge clk);
    check("err_illegal_sat",  {127'd0, bus_a.err}, 128'd1);
    check("err_illegal_wrap", {127'd0, bus_b.err}, 128'd1);
    drain();

    // Mode mismatch: int32 non-first after int8 first restarts with 7 * 9
    do_reset();
    check("err_after_reset", {127'd0, bus_a.err | bus_b.err}, '0);
    expect_res(128'd63, 1'b0, 128'd63, 1'b0);
    send(2'b00, 1'b1, 1'b1, 1'b0, 64'h05, 64'h05);
    send(2'b10, 1'b1, 1'b0, 1'b1, 64'd7, 64'd9);
    idle();
    drain();
    check("err_mismatch_sat",  {127'd0, bus_a.err}, 128'd1);
    check("err_mismatch_wrap", {127'd0, bus_b.err}, 128'd1);

    // Reset mid-burst discards partial work; then int32 signed 3 * -2
    send(2'b01, 1'b0, 1'b1, 1'b0, 64'h0001_0001_0001_0001, 64'h0002_0002_0002_0002);
    send(2'b01, 1'b0, 1'b0, 1'b0, 64'h0001_0001_0001_0001, 64'h0002_0002_0002_0002);
    do_reset();
    check_cleared("midreset");
    repeat (5) @(negedge clk);
    check("midreset_no_valid", {127'd0, bus_a.out_valid | bus_b.out_valid}, '0);
    expect_res({64'd0, 64'hFFFF_FFFF_FFFF_FFFA}, 1'b0, {64'd0, 64'hFFFF_FFFF_FFFF_FFFA}, 1'b0);
    send(2'b10, 1'b1, 1'b1, 1'b1, 64'd3, 64'h0000_0000_FFFF_FFFE);
    idle();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/simd_mac_pipe.md
Name: simd_mac_pipe

Overview:
- Parametrised, precision-configurable SIMD multiply-accumulate unit for the DTPU datapath. It is the successor of the single-shot sub-multiplier.
- Each beat splits DATA_WIDTH-bit input/weight words into 8-, 16- or 32-bit lanes, multiplies lane-wise (signed or unsigned) and accumulates across a burst delimited by first/last flags.
- Full-precision lane results come out through a valid/ready interface.
- It sits between the weight/activation feeders and the output buffer.

Parameters:
- DATA_WIDTH, 64, operand word width; must be a multiple of 32.
- SATURATE, 1, 1 = saturating accumulate, 0 = two's-complement wrap.
- USE_FABRIC, "NO", "NO" = multipliers carry a use_dsp synthesis attribute, "YES" = fabric LUTs; no functional difference.

Ports:
- clk  in  1  clock; all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- input_data  in  DATA_WIDTH  activations, packed lanes.
- weight  in  DATA_WIDTH  weights, packed lanes.
- prec_mode  in  2  00 = int8, 01 = int16, 10 = int32, 11 = illegal.
- is_signed  in  1  1 = signed lane operands.
- in_first  in  1  beat starts a new accumulation.
- in_last  in  1  beat ends the accumulation; result emitted.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- res_mac  out  2*DATA_WIDTH  packed accumulators; lane i of width W occupies bits [2W*i+2W-1 : 2W*i].
- ovf  out  1  sticky overflow/saturation flag for the current burst.
- err  out  1  sticky illegal-mode / mode-mismatch flag.

Behaviour:
- Reset (resetn=0 at an edge):
  - All pipeline registers, accumulators, res_mac, ovf and err are cleared; out_valid=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-burst discards all in-flight beats and the partial accumulation.
- Lanes:
  - W = 8/16/32 gives DATA_WIDTH/W lanes.
  - Lane i operands are input_data[W*i+W-1 : W*i] and weight[W*i+W-1 : W*i].
  - Product is 2W bits, exact; accumulator lane is 2W bits.
- Pipeline, 3 stages:
  - S1: register operands and control.
  - S2: register lane products.
  - S3: accumulate.
  - A beat accepted at edge t updates the accumulator at edge t+2.
  - If the beat has in_last, out_valid=1 and res_mac equals the final accumulator from cycle t+3 when not stalled.
  - Back-to-back beats are accepted every cycle; no bubbles are required.
- Accumulate:
  - first=1: acc = product.
  - Otherwise: acc = acc + product.
  - A beat with first=1 and last=1 is a single-shot multiply.
  - The result register is separate from the accumulator, so a new burst may begin the cycle after a last beat.
- Saturation (SATURATE=1):
  - Signed: clamp to [-2^(2W-1), 2^(2W-1)-1].
  - Unsigned: clamp to 2^(2W)-1.
  - Any lane clamp sets ovf.
- Wrap (SATURATE=0): result wraps; ovf is set on signed or unsigned overflow of any lane.
- ovf clears when a first beat reaches S3.
- Mode rules:
  - The accumulator remembers the prec_mode and is_signed of its first beat.
  - A non-first beat whose mode differs from the stored mode sets err and is treated as first.
  - prec_mode=11: the beat is accepted and dropped (no accumulator change, no output), and err is set.
  - err clears only on reset.
- Backpressure:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - While stalled, every stage freezes and res_mac, ovf and out_valid hold stable.
  - A result leaves on an edge with out_valid & out_ready. out_valid drops the next cycle unless a new last beat completes on the same edge, in which case the new result is loaded and out_valid stays 1.
- Non-last beats never assert out_valid.
- Unused upper res_mac bits: none. All 2*DATA_WIDTH bits are always driven by the active mode's lanes.

Test Plan:
- int8 signed single shot: lane0 operands 0x7F × 0x02, other lanes 0, first=last=1 -> 3 cycles later out_valid=1, res_mac[15:0]=0x00FE, remaining bits 0, ovf=0.
- int16 unsigned burst: 4 beats, each lane 1000×1000 (0x03E8), first on beat0, last on beat3 -> one result; every 32-bit lane = 0x003D0900; out_valid high for exactly one cycle with out_ready=1.
- int8 signed saturation: 3 beats of 0x80×0x80 (+16384 each) -> lane = 0x7FFF, ovf=1. The same with SATURATE=0 -> lane = 0xC000, ovf=1. The next burst's first beat clears ovf.
- Backpressure: hold out_ready=0 while a result is valid, feeding beats continuously -> in_ready=0, res_mac stable; no beat is lost after out_ready returns; results match a reference model in order.
- Illegal and mismatched mode: a prec_mode=11 beat -> no output, err=1. An int32 non-first beat after an int8 first -> err=1, and the accumulator restarts with the int32 product.
- Reset mid-burst: resetn=0 for one cycle after 2 of 4 beats -> outputs zero, no out_valid. A following first/last int32 beat of 3×(-2) signed -> res_mac[63:0]=0xFFFFFFFFFFFFFFFA.
